// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the multi-cycle core and its data memory.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [63:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: one request at a time, masked stores into a 64-bit little-endian RAM,
// extended loads, and a single-cycle response after a fixed latency.
module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1
) (
  input logic                 clk,
  input logic                 reset,
  data_mem_responder_if.slave bus
);

  localparam int unsigned IdxW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned AddrMsb   = IdxW + 2;
  localparam logic [63:0] ByteLimit = 64'(DEPTH_WORDS) << 3;
  localparam logic [3:0]  CntInit   = 4'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        ready_q;
  logic        valid_q;
  logic        err_q;
  logic [63:0] rdata_q;
  logic [63:0] hold_q;
  logic        hold_err_q;

  logic [63:0] mem_q [DEPTH_WORDS];

  logic           accept;
  logic           misaligned;
  logic           out_of_range;
  logic           req_err;
  logic [IdxW-1:0] word_idx;
  logic [2:0]     lane;
  logic [7:0]     be;
  logic [63:0]    rd_word;
  logic [63:0]    rd_shift;
  logic [63:0]    wr_shift;
  logic [63:0]    wr_word;
  logic [63:0]    ld_data;

  assign accept       = bus.req_valid & ready_q;
  assign lane         = bus.req_addr[2:0];
  assign word_idx     = bus.req_addr[AddrMsb:3];
  assign out_of_range = (bus.req_addr >= ByteLimit);
  assign req_err      = misaligned | out_of_range;
  assign rd_word      = mem_q[word_idx];
  assign rd_shift     = rd_word >> {lane, 3'b000};
  assign wr_shift     = bus.req_wdata << {lane, 3'b000};

  always_comb begin
    misaligned = 1'b0;
    be         = 8'h00;
    unique case (bus.req_size)
      2'b00: begin misaligned = 1'b0;        be = 8'h01 << lane; end
      2'b01: begin misaligned = lane[0];     be = 8'h03 << lane; end
      2'b10: begin misaligned = |lane[1:0];  be = 8'h0F << lane; end
      2'b11: begin misaligned = |lane;       be = 8'hFF;         end
    endcase
  end

  // Read-modify-write merge: only the addressed byte lanes take new data.
  always_comb begin
    wr_word = rd_word;
    for (int k = 0; k < 8; k++) begin
      if (be[k]) wr_word[8*k +: 8] = wr_shift[8*k +: 8];
    end
  end

  always_comb begin
    ld_data = 64'h0;
    if (!bus.req_write && !req_err) begin
      unique case (bus.req_size)
        2'b00: ld_data = {{56{~bus.req_unsigned & rd_shift[7]}},  rd_shift[7:0]};
        2'b01: ld_data = {{48{~bus.req_unsigned & rd_shift[15]}}, rd_shift[15:0]};
        2'b10: ld_data = {{32{~bus.req_unsigned & rd_shift[31]}}, rd_shift[31:0]};
        2'b11: ld_data = rd_word;
      endcase
    end
  end

  // RAM has no reset so committed stores survive a mid-operation reset.
  always_ff @(posedge clk) begin
    if (accept && bus.req_write && !req_err) begin
      mem_q[word_idx] <= wr_word;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= 64'h0;
      hold_q     <= 64'h0;
      hold_err_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            cnt_q   <= CntInit;
            ready_q <= 1'b0;
            if (LATENCY > 1) begin
              state_q    <= StWait;
              hold_q     <= ld_data;
              hold_err_q <= req_err;
            end else begin
              state_q <= StResp;
              valid_q <= 1'b1;
              rdata_q <= ld_data;
              err_q   <= req_err;
            end
          end
        end
        StWait: begin
          if (cnt_q == 4'd1) begin
            state_q <= StResp;
            cnt_q   <= 4'd0;
            valid_q <= 1'b1;
            rdata_q <= hold_q;
            err_q   <= hold_err_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
          valid_q <= 1'b0;
          rdata_q <= 64'h0;
          err_q   <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: a LATENCY=1 and a LATENCY=3 responder sharing one stimulus bus.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst1, rst3, sel;
  logic        valid, write, uns;
  logic [63:0] addr, wdata;
  logic [1:0]  size;

  data_mem_responder_if m1 ();
  data_mem_responder_if m3 ();

  assign m1.req_valid    = valid & ~sel;
  assign m1.req_write    = write;
  assign m1.req_addr     = addr;
  assign m1.req_size     = size;
  assign m1.req_unsigned = uns;
  assign m1.req_wdata    = wdata;
  assign m3.req_valid    = valid & sel;
  assign m3.req_write    = write;
  assign m3.req_addr     = addr;
  assign m3.req_size     = size;
  assign m3.req_unsigned = uns;
  assign m3.req_wdata    = wdata;

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
    .clk   (clk),
    .reset (rst1),
    .bus   (m1.slave)
  );

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) dut3 (
    .clk   (clk),
    .reset (rst3),
    .bus   (m3.slave)
  );

  logic        ready_s, rv_s, err_s;
  logic [63:0] rdata_s;
  assign ready_s = sel ? m3.req_ready  : m1.req_ready;
  assign rv_s    = sel ? m3.resp_valid : m1.resp_valid;
  assign err_s   = sel ? m3.resp_err   : m1.resp_err;
  assign rdata_s = sel ? m3.resp_rdata : m1.resp_rdata;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        write;
    logic [63:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic add(input logic w, input logic [63:0] a, input logic [1:0] s, input logic u,
                     input logic [63:0] wd, input logic [63:0] er, input logic ee);
    vec_t v;
    v.write = w; v.addr = a; v.size = s; v.uns = u; v.wdata = wd;
    v.exp_rdata = er; v.exp_err = ee;
    vecs.push_back(v);
  endtask

  task automatic txn(input logic w, input logic [63:0] a, input logic [1:0] s, input logic u,
                     input logic [63:0] wd, output logic [63:0] rd, output logic er,
                     output int lat);
    int guard;
    @(negedge clk);
    write = w; addr = a; size = s; uns = u; wdata = wd; valid = 1'b1;
    guard = 0;
    while (!ready_s && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("req_ready_before_accept", {63'b0, ready_s}, 64'h1);
    @(posedge clk);
    #1 valid = 1'b0;
    lat = 99; rd = 64'h0; er = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (rv_s) begin
        lat = n; rd = rdata_s; er = err_s;
        break;
      end
    end
    @(negedge clk);
    check("resp_pulse_one_cycle", {63'b0, rv_s}, 64'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] rd;
    logic        er;
    int          lat;

    rst1 = 1'b0; rst3 = 1'b0; sel = 1'b0; valid = 1'b0;
    write = 1'b0; addr = 64'h0; size = 2'd0; uns = 1'b0; wdata = 64'h0;

    // Reset state of both instances.
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      sel = d[0];
      #1;
      check($sformatf("rst%0d_ready", d), {63'b0, ready_s}, 64'h1);
      check($sformatf("rst%0d_valid", d), {63'b0, rv_s}, 64'h0);
      check($sformatf("rst%0d_err", d), {63'b0, err_s}, 64'h0);
      check($sformatf("rst%0d_rdata", d), rdata_s, 64'h0);
    end
    @(negedge clk);
    rst1 = 1'b1; rst3 = 1'b1; sel = 1'b0;

    //   write addr              size uns wdata                    exp_rdata              err
    add(1'b1, 64'h10,   2'd3, 1'b0, 64'h1122334455667788, 64'h0, 1'b0);
    add(1'b0, 64'h10,   2'd3, 1'b0, 64'h0, 64'h1122334455667788, 1'b0);
    add(1'b1, 64'h13,   2'd0, 1'b0, 64'h00000000000000AB, 64'h0, 1'b0);
    add(1'b0, 64'h10,   2'd3, 1'b1, 64'h0, 64'h11223344AB667788, 1'b0);
    add(1'b0, 64'h13,   2'd0, 1'b0, 64'h0, 64'hFFFFFFFFFFFFFFAB, 1'b0);
    add(1'b0, 64'h13,   2'd0, 1'b1, 64'h0, 64'h00000000000000AB, 1'b0);
    add(1'b0, 64'h16,   2'd1, 1'b0, 64'h0, 64'h0000000000001122, 1'b0);
    add(1'b0, 64'h12,   2'd1, 1'b0, 64'h0, 64'hFFFFFFFFFFFFAB66, 1'b0);
    add(1'b0, 64'h12,   2'd1, 1'b1, 64'h0, 64'h000000000000AB66, 1'b0);
    add(1'b0, 64'h10,   2'd2, 1'b0, 64'h0, 64'hFFFFFFFFAB667788, 1'b0);
    add(1'b0, 64'h10,   2'd0, 1'b0, 64'h0, 64'hFFFFFFFFFFFFFF88, 1'b0);
    add(1'b1, 64'h18,   2'd2, 1'b0, 64'h0000000080000001, 64'h0, 1'b0);
    add(1'b0, 64'h18,   2'd2, 1'b0, 64'h0, 64'hFFFFFFFF80000001, 1'b0);
    add(1'b0, 64'h18,   2'd2, 1'b1, 64'h0, 64'h0000000080000001, 1'b0);
    add(1'b1, 64'h12,   2'd2, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b1);
    add(1'b1, 64'h11,   2'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1'b1);
    add(1'b0, 64'h14,   2'd3, 1'b0, 64'h0, 64'h0, 1'b1);
    add(1'b0, 64'h10,   2'd3, 1'b0, 64'h0, 64'h11223344AB667788, 1'b0);
    add(1'b0, 64'h2000, 2'd3, 1'b0, 64'h0, 64'h0, 1'b1);
    add(1'b0, 64'h8000000000000010, 2'd3, 1'b0, 64'h0, 64'h0, 1'b1);
    add(1'b1, 64'h1FF8, 2'd3, 1'b0, 64'hCAFEF00D12345678, 64'h0, 1'b0);
    add(1'b1, 64'h1FFF, 2'd0, 1'b0, 64'hFFFFFFFFFFFFFF5A, 64'h0, 1'b0);
    add(1'b0, 64'h1FF8, 2'd3, 1'b0, 64'h0, 64'h5AFEF00D12345678, 1'b0);
    add(1'b0, 64'h1FFF, 2'd0, 1'b0, 64'h0, 64'h000000000000005A, 1'b0);

    foreach (vecs[i]) begin
      txn(vecs[i].write, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata, rd, er, lat);
      check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("v%0d_err", i), {63'b0, er}, {63'b0, vecs[i].exp_err});
      check($sformatf("v%0d_latency", i), 64'(lat), 64'd1);
    end

    // LATENCY=3 with req_valid held high: accepts every 4 cycles.
    @(negedge clk);
    sel = 1'b1; write = 1'b0; addr = 64'h0; size = 2'd3; uns = 1'b0; valid = 1'b1;
    #1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("stream_c%0d_ready", i), {63'b0, ready_s}, {63'b0, (i % 4) == 0});
      check($sformatf("stream_c%0d_valid", i), {63'b0, rv_s}, {63'b0, (i % 4) == 3});
      @(negedge clk);
    end
    valid = 1'b0;
    @(negedge clk);

    // LATENCY=3 store interrupted by reset one cycle after acceptance.
    write = 1'b1; addr = 64'h20; size = 2'd3; wdata = 64'hDEADBEEF00000000; valid = 1'b1;
    check("rstmid_ready_pre", {63'b0, ready_s}, 64'h1);
    @(posedge clk);
    #1 valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst3 = 1'b0;
    #1;
    check("rstmid_ready_in_reset", {63'b0, ready_s}, 64'h1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rstmid_noresp_%0d", i), {63'b0, rv_s}, 64'h0);
    end
    rst3 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rstmid_post_ready_%0d", i), {63'b0, ready_s}, 64'h1);
      check($sformatf("rstmid_post_noresp_%0d", i), {63'b0, rv_s}, 64'h0);
    end
    txn(1'b0, 64'h20, 2'd3, 1'b0, 64'h0, rd, er, lat);
    check("rstmid_ld_rdata", rd, 64'hDEADBEEF00000000);
    check("rstmid_ld_err", {63'b0, er}, 64'h0);
    check("rstmid_ld_latency", 64'(lat), 64'd3);

    // LATENCY=3 error response path.
    txn(1'b0, 64'h2000, 2'd3, 1'b0, 64'h0, rd, er, lat);
    check("l3_oor_rdata", rd, 64'h0);
    check("l3_oor_err", {63'b0, er}, 64'h1);
    check("l3_oor_latency", 64'(lat), 64'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder side of the data-memory interface driven by the multi-cycle control unit and datapath.
- Accepts one load or store request at a time, holds a 64-bit-wide little-endian RAM, and applies byte/half/word/dword store masking.
- Sign- or zero-extends loaded data and returns a one-shot response after a fixed, parameterised latency.
- Flags misaligned and out-of-range accesses instead of corrupting memory.

Parameters:
- DEPTH_WORDS, 1024, number of 64-bit RAM words; byte address range is 0 .. DEPTH_WORDS*8-1.
- LATENCY, 1, cycles from request acceptance to resp_valid; legal values are 1..15.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  64  byte address.
- req_size  input  2  access size: 00 byte, 01 half, 10 word, 11 dword.
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend; ignored for dword.
- req_wdata  input  64  store data; the low 8*2^size bits are used.
- resp_valid  output  1  single-cycle response pulse.
- resp_rdata  output  64  extended load data; 0 for stores and errors.
- resp_err  output  1  misaligned or out-of-range access.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0.
  - RAM contents are not cleared.
- States:
  - IDLE: req_ready=1. The handshake completes on a rising edge with req_valid=1 and req_ready=1.
    - At that edge: latch size, unsigned flag, addr[2:0] and the error flag.
    - Store with no error: write the masked byte lanes at that same edge.
    - Load with no error: capture the addressed 64-bit RAM word at that same edge.
    - Load counter with LATENCY-1, then go to WAIT if LATENCY>1, otherwise to RESP.
  - WAIT: req_ready=0; decrement the counter each cycle; go to RESP when it reaches 0.
  - RESP: resp_valid=1 for exactly one cycle, with resp_rdata and resp_err registered; req_ready=0; next state is IDLE.
  - Net effect: resp_valid rises LATENCY cycles after the accepting edge. A new request can be accepted on the edge that leaves RESP, so peak throughput is one request per LATENCY+1 cycles.
- Error conditions:
  - Misaligned: addr[0]≠0 for half; addr[1:0]≠0 for word; addr[2:0]≠0 for dword.
  - Out of range: addr ≥ DEPTH_WORDS*8.
  - On error: no RAM write; response has resp_err=1 and resp_rdata=0.
- Stores: lane index = addr[2:0]. req_wdata[8k+7:8k] goes to byte addr[2:0]+k for k < 2^size. All other bytes of the word are unchanged.
- Loads:
  - Extract 2^size bytes starting at lane addr[2:0].
  - req_unsigned=1 zero-extends to 64 bits; req_unsigned=0 replicates the top extracted bit.
  - dword loads return the word as-is.
- Word index = addr[ADDR_MSB:3], where ADDR_MSB = $clog2(DEPTH_WORDS)+2.
- req_valid during WAIT or RESP is ignored; the requester must hold the request until req_ready=1.
- Reset mid-operation:
  - A pending response is discarded; resp_valid stays 0 and the block returns to IDLE.
  - A store accepted before reset remains committed.
- Store then load to the same address in consecutive transactions: the load sees the stored data. Read-after-write within the RAM must not return stale data.
- The request fields are don't-care when no handshake takes place.

Test Plan:
- LATENCY=1. SD 0x1122334455667788 to 0x10, then LD 0x10 → resp_valid exactly 1 cycle after each accept, rdata=0x1122334455667788, err=0.
- Byte store and loads:
  - SB wdata=0xAB at 0x13, then LD 0x10 → 0x11223344AB667788.
  - LB signed at 0x13 → 0xFFFFFFFFFFFFFFAB.
  - LBU at 0x13 → 0x00000000000000AB.
- Half and word loads:
  - LH signed at 0x16 → 0x0000000000001122.
  - SW 0x80000001 at 0x18, then LW signed at 0x18 → 0xFFFFFFFF80000001.
  - LW unsigned at 0x18 → 0x0000000080000001.
- Errors:
  - SW at 0x12 → err=1, rdata=0; a following LD 0x10 still returns 0x11223344AB667788.
  - LD at DEPTH_WORDS*8 → err=1.
- LATENCY=3, req_valid held high continuously → accepts spaced 4 cycles apart, req_ready=0 for 3 cycles after each accept, resp_valid 3 cycles after each accept.
- LATENCY=3. SD 0xDEADBEEF00000000 at 0x20, reset asserted 1 cycle after accept → no resp_valid; after reset release req_ready=1; LD 0x20 → 0xDEADBEEF00000000.
